// File: rtl/pu_io_dispatch.sv
// pu_io_dispatch: per-PU I/O dispatcher to the PU-side memory targets.
// Define PU_IO_TIMEOUT_EN to abandon requests whose ack never arrives.
`ifndef PU_WIDTH_NBITS
`define PU_WIDTH_NBITS 32
`endif
`ifndef RESET_SIG
`define RESET_SIG rst
`endif
`ifndef PU_MEM_MULTI_DEPTH_RANGE
`define PU_MEM_MULTI_DEPTH_RANGE 18:16
`endif

package pu_io_pkg;
   localparam int MULTI_NBITS = 3;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [7:0]  fid;
      logic [31:0] wdata;
   } io_type;
endpackage

module pu_io_dispatch
   import pu_io_pkg::*;
#(
   parameter int         WIDTH_NBITS    = `PU_WIDTH_NBITS,
   parameter int         NUM_TGT        = 4,
   parameter int         TGT_NBITS      = 2,
   parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
   input  logic                                 clk,
   input  logic                                 `RESET_SIG,
   input  logic                                 pu_req,
   input  io_type                               pu_cmd,
   output logic                                 pu_busy,
   output logic                                 pu_ack,
   output logic [WIDTH_NBITS-1:0]               pu_ack_data,
   output logic [NUM_TGT-1:0]                   tgt_req,
   output io_type                               tgt_cmd,
   input  logic [NUM_TGT-1:0]                   tgt_ack,
   input  logic [NUM_TGT-1:0][WIDTH_NBITS-1:0]  tgt_ack_data,
   output logic [7:0]                           drop_cnt,
   output logic                                 stray_ack,
   output logic                                 timeout_err
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE_NULL
   } state_t;

   state_t                 state;
   logic [TGT_NBITS-1:0]   sel;
   logic [MULTI_NBITS-1:0] field;
   logic [TGT_NBITS-1:0]   idx;
   logic                   mapped;
   logic [NUM_TGT-1:0]     sel_oh;
   logic [NUM_TGT-1:0]     stray_vec;

   assign field  = pu_cmd.addr[`PU_MEM_MULTI_DEPTH_RANGE];
   assign idx    = TGT_NBITS'(field);
   assign mapped = 32'(field) < NUM_TGT;
   assign sel_oh = NUM_TGT'(1) << sel;

   // Only the selected lane is legal, and only while waiting.
   assign stray_vec = (state == WAIT) ? (tgt_ack & ~sel_oh)
                                      : tgt_ack;

`ifdef PU_IO_TIMEOUT_EN
   logic [7:0] wait_cnt;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign timeout_err    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (`RESET_SIG) begin
         state       <= IDLE;
         sel         <= '0;
         tgt_cmd     <= '0;
         tgt_req     <= '0;
         pu_busy     <= 1'b0;
         pu_ack      <= 1'b0;
         pu_ack_data <= '0;
         drop_cnt    <= '0;
         stray_ack   <= 1'b0;
`ifdef PU_IO_TIMEOUT_EN
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
`endif
      end else begin
         tgt_req     <= '0;
         pu_ack      <= 1'b0;
         pu_ack_data <= '0;

         if (|stray_vec)
            stray_ack <= 1'b1;

         if (pu_req && state != IDLE && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;

         unique case (state)
            IDLE: begin
               if (pu_req) begin
                  tgt_cmd <= pu_cmd;
                  sel     <= idx;
                  pu_busy <= 1'b1;
`ifdef PU_IO_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
                  if (mapped) begin
                     tgt_req <= NUM_TGT'(1) << idx;
                     state   <= WAIT;
                  end else begin
                     state   <= DONE_NULL;
                  end
               end
            end
            WAIT: begin
               if (tgt_ack[sel]) begin
                  pu_ack      <= 1'b1;
                  pu_ack_data <= tgt_ack_data[sel];
                  pu_busy     <= 1'b0;
                  state       <= IDLE;
               end
`ifdef PU_IO_TIMEOUT_EN
               else if (wait_cnt == TIMEOUT_CYCLES) begin
                  pu_ack      <= 1'b1;
                  timeout_err <= 1'b1;
                  pu_busy     <= 1'b0;
                  state       <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
`endif
            end
            DONE_NULL: begin
               pu_ack  <= 1'b1;
               pu_busy <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
